// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX->MEM pipeline register sitting directly behind the ALU.
//
// Registers the ALU result and writeback information behind a valid/ready
// handshake with a two-entry buffer (main + skid). Register writes are
// squashed for rd==0 and for trapping ops that overflowed. The first
// trapping overflow raises an exception (with its PC) to the control unit,
// which holds until exc_ack.
//
// Handshake: a beat moves whenever valid && ready on the same rising edge.
// in_ready is a register output (!skid_full), so it never depends
// combinationally on out_ready. An input offered while flush is high is
// discarded even if in_ready is 1.
//
// Optional feature macro: OVF_COUNT_EN adds the ovf_count output, a
// saturating count of accepted trapping overflows.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   ALU-side handshake
//   in_result, in_overflow, in_chk_ovf, in_rd, in_wr_en, in_pc  entry fields
//   flush               squash every buffered entry and the current offer
//   out_valid/out_ready MEM-side handshake
//   out_result, out_rd, out_wr_en  head-of-buffer entry (wr_en qualified)
//   exc_valid, exc_pc, exc_ack     overflow exception to the control unit
//   ovf_count           (OVF_COUNT_EN only) accepted-overflow counter
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic              in_chk_ovf,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr_en,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr_en,
    output logic              exc_valid,
    output logic [PC_W-1:0]   exc_pc,
    input  logic              exc_ack
`ifdef OVF_COUNT_EN
    ,
    output logic [15:0]       ovf_count
`endif
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_result_q, main_result_d;
    logic [REG_AW-1:0] main_rd_q, main_rd_d;
    logic              main_wr_q, main_wr_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_result_q, skid_result_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic              skid_wr_q, skid_wr_d;

    logic              exc_valid_q, exc_valid_d;
    logic [PC_W-1:0]   exc_pc_q, exc_pc_d;

    logic acc;
    logic xfer;
    logic ovf_trap;
    logic new_wr;
    logic exc_set;

    assign in_ready = !skid_valid_q;
    assign acc      = in_valid && in_ready && !flush;
    assign xfer     = main_valid_q && out_ready;
    assign ovf_trap = in_chk_ovf && in_overflow;
    // Result is kept as-is; only the write enable is squashed.
    assign new_wr   = in_wr_en && (in_rd != '0) && !ovf_trap;
    // First-wins: a pending exception is only replaced when it is being acked.
    assign exc_set  = acc && ovf_trap && (!exc_valid_q || exc_ack);

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_rd_d     = main_rd_q;
        main_wr_d     = main_wr_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        skid_wr_d     = skid_wr_q;

        if (flush) begin
            // Any transfer this cycle still completes; the buffer just ends empty.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer && skid_valid_q) begin
            // in_ready is 0 here, so no new entry can arrive this cycle.
            main_result_d = skid_result_q;
            main_rd_d     = skid_rd_q;
            main_wr_d     = skid_wr_q;
            skid_valid_d  = 1'b0;
        end else if (xfer || !main_valid_q) begin
            main_valid_d = acc;
            if (acc) begin
                main_result_d = in_result;
                main_rd_d     = in_rd;
                main_wr_d     = new_wr;
            end
        end else if (acc) begin
            // Main is stalled: park the new entry in the skid slot.
            skid_valid_d  = 1'b1;
            skid_result_d = in_result;
            skid_rd_d     = in_rd;
            skid_wr_d     = new_wr;
        end
    end

    always_comb begin
        exc_valid_d = exc_valid_q;
        exc_pc_d    = exc_pc_q;
        if (exc_set) begin
            exc_valid_d = 1'b1;
            exc_pc_d    = in_pc;
        end else if (exc_ack) begin
            exc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q  <= 1'b0;
            main_result_q <= '0;
            main_rd_q     <= '0;
            main_wr_q     <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_wr_q     <= 1'b0;
            exc_valid_q   <= 1'b0;
            exc_pc_q      <= '0;
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_rd_q     <= main_rd_d;
            main_wr_q     <= main_wr_d;
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
            skid_wr_q     <= skid_wr_d;
            exc_valid_q   <= exc_valid_d;
            exc_pc_q      <= exc_pc_d;
        end
    end

`ifdef OVF_COUNT_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (acc && ovf_trap && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

    assign out_valid  = main_valid_q;
    assign out_result = main_result_q;
    assign out_rd     = main_rd_q;
    assign out_wr_en  = main_wr_q;
    assign exc_valid  = exc_valid_q;
    assign exc_pc     = exc_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid, in_ready, in_overflow, in_chk_ovf, in_wr_en;
  logic [31:0] in_result, in_pc;
  logic [4:0]  in_rd;
  logic        flush, out_valid, out_ready, out_wr_en;
  logic [31:0] out_result, exc_pc;
  logic [4:0]  out_rd;
  logic        exc_valid, exc_ack;
`ifdef OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  ex_mem_stage #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_chk_ovf(in_chk_ovf), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_ack(exc_ack)
`ifdef OVF_COUNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // Entry packing: {wr_en, rd, result}. The stage behaves as a 2-deep FIFO.
  logic [37:0] exp_q[$];
  logic        m_exc;
  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_acc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      chk("out_result", 64'(out_result), 64'(exp_q[0][31:0]));
      chk("out_rd", 64'(out_rd), 64'(exp_q[0][36:32]));
      chk("out_wr_en", 64'(out_wr_en), 64'(exp_q[0][37]));
    end
    chk("exc_valid", 64'(exc_valid), 64'(m_exc));
    chk("exc_pc", 64'(exc_pc), 64'(m_pc));
`ifdef OVF_COUNT_EN
    chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
`endif
  endtask

  // Advance one clock: update the model from the current inputs, then check.
  task automatic tick();
    logic        xfer, ovf;
    logic [37:0] ent, dummy;
    m_acc = in_valid && (exp_q.size() < 2) && !flush;
    xfer  = (exp_q.size() != 0) && out_ready;
    ovf   = m_acc && in_chk_ovf && in_overflow;
    ent   = {in_wr_en && (in_rd != 5'd0) && !(in_chk_ovf && in_overflow), in_rd, in_result};
    if (ovf && (!m_exc || exc_ack)) begin
      m_exc = 1'b1;
      m_pc  = in_pc;
    end else if (exc_ack) begin
      m_exc = 1'b0;
    end
    if (ovf && m_cnt < 65535) m_cnt++;
    if (xfer) dummy = exp_q.pop_front();
    if (flush) exp_q.delete();
    else if (m_acc) exp_q.push_back(ent);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] res, input logic ovf, input logic c,
                       input logic [4:0] rd, input logic wr, input logic [31:0] pc);
    in_valid = v; in_result = res; in_overflow = ovf; in_chk_ovf = c;
    in_rd = rd; in_wr_en = wr; in_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  // Offer an entry and hold it until the model says it was accepted (bounded).
  task automatic send(input logic [31:0] res, input logic ovf, input logic c,
                      input logic [4:0] rd, input logic wr, input logic [31:0] pc);
    logic got;
    got = 1'b0;
    drive(1'b1, res, ovf, c, rd, wr, pc);
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = m_acc;
    end
    chk("send_accepted", 64'(got), 64'd1);
    idle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_exc = 1'b0;
    m_pc  = 32'd0;
    m_cnt = 0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wr_en", 64'(out_wr_en), 64'd0);
    chk("rst_exc_valid", 64'(exc_valid), 64'd0);
    chk("rst_exc_pc", 64'(exc_pc), 64'd0);
`ifdef OVF_COUNT_EN
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    flush = 1'b0; out_ready = 1'b1; exc_ack = 1'b0;
    m_acc = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    @(posedge clk);
    #1;

    // 1: single entry, one-cycle latency
    drive(1'b1, 32'h5, 1'b0, 1'b0, 5'd3, 1'b1, 32'h100);
    tick();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_result", 64'(out_result), 64'h5);
    chk("t1_out_rd", 64'(out_rd), 64'd3);
    chk("t1_out_wr_en", 64'(out_wr_en), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    idle();
    tick();

    // 2: back-pressure fills the skid, then FIFO drain A,B,C
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 1'b0, 1'b0, 5'd1, 1'b1, 32'h200);
    tick();
    drive(1'b1, 32'h2, 1'b0, 1'b0, 5'd2, 1'b1, 32'h204);
    tick();
    chk("t2_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h3, 1'b0, 1'b0, 5'd3, 1'b1, 32'h208);
    tick();
    chk("t2_c_held", 64'(m_acc), 64'd0);
    chk("t2_head_a", 64'(out_result), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("t2_head_b", 64'(out_result), 64'h2);
    tick();
    chk("t2_c_taken", 64'(m_acc), 64'd1);
    chk("t2_head_c", 64'(out_result), 64'h3);
    idle();
    tick();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // 3: trapping overflow, first-wins, ack
    send(32'hDEAD, 1'b1, 1'b1, 5'd8, 1'b1, 32'h0040_0010);
    chk("t3_wr_squash", 64'(out_wr_en), 64'd0);
    chk("t3_exc_valid", 64'(exc_valid), 64'd1);
    chk("t3_exc_pc", 64'(exc_pc), 64'h0040_0010);
    send(32'hBEEF, 1'b1, 1'b1, 5'd9, 1'b1, 32'h0040_0014);
    chk("t3_first_wins", 64'(exc_pc), 64'h0040_0010);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("t3_ack_clear", 64'(exc_valid), 64'd0);
    chk("t3_pc_hold", 64'(exc_pc), 64'h0040_0010);
    tick();

    // 4: non-trapping overflow keeps write; rd==0 squashes
    send(32'h7, 1'b1, 1'b0, 5'd9, 1'b1, 32'h300);
    chk("t4_addu_wr", 64'(out_wr_en), 64'd1);
    chk("t4_no_exc", 64'(exc_valid), 64'd0);
    send(32'h8, 1'b0, 1'b0, 5'd0, 1'b1, 32'h304);
    chk("t4_rd0_wr", 64'(out_wr_en), 64'd0);
    chk("t4_rd0_result", 64'(out_result), 64'h8);
    tick();

    // 5: full buffer, flush with a faulting offer
    out_ready = 1'b0;
    send(32'h10, 1'b1, 1'b1, 5'd4, 1'b1, 32'h500);
    send(32'h11, 1'b0, 1'b0, 5'd5, 1'b1, 32'h504);
    chk("t5_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h12, 1'b1, 1'b1, 5'd6, 1'b1, 32'h600);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_ready", 64'(in_ready), 64'd1);
    chk("t5_exc_kept", 64'(exc_valid), 64'd1);
    chk("t5_exc_pc_kept", 64'(exc_pc), 64'h500);
    out_ready = 1'b1;
    tick();
    chk("t5_nothing", 64'(out_valid), 64'd0);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;

    // 6: counter and async reset with skid full
    apply_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'(i), 1'b1, 1'b1, 5'd7, 1'b1, 32'h700 + 32'(4 * i));
    tick();
`ifdef OVF_COUNT_EN
    chk("t6_count3", 64'(ovf_count), 64'd3);
`endif
    out_ready = 1'b0;
    send(32'h21, 1'b0, 1'b0, 5'd1, 1'b1, 32'h800);
    send(32'h22, 1'b0, 1'b0, 5'd2, 1'b1, 32'h804);
    chk("t6_skid_full", 64'(in_ready), 64'd0);
    apply_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // random phase
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom());
      flush     = ($urandom_range(0, 15) == 0);
      exc_ack   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    flush = 1'b0; exc_ack = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("drained", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
